// File: rtl/axi4_top.sv
// axi4_top: single-beat AXI4-Lite-style traffic block.
// After reset the master issues one write (AW+W), waits for B, issues one read (AR), waits
// for R and captures the returned data. An internal slave-side generator drives the AW, W and
// AR readies. B and R valids and read data come from outside. Every output is a register.
module axi4_top #(
    parameter logic [31:0] WR_ADDR = 32'h0000_0010,
    parameter logic [31:0] WR_DATA = 32'hDEAD_BEEF,
    parameter logic [31:0] RD_ADDR = 32'h0000_0010
) (
    input  logic        clk,
    input  logic        reset_n,     // active-high synchronous reset despite the name
    output logic [31:0] awaddr,
    output logic        awvalid,
    output logic        awready,
    output logic [31:0] wdata,
    output logic        wvalid,
    output logic        wready,
    input  logic        bvalid,
    output logic        bready,
    output logic [31:0] araddr,
    output logic        arvalid,
    output logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] rd_data_q,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITE     = 3'd1,
        WAIT_B    = 3'd2,
        READ_ADDR = 3'd3,
        WAIT_R    = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Master-side output registers
    logic [31:0] r_awaddr;
    logic        r_awvalid;
    logic [31:0] r_wdata;
    logic        r_wvalid;
    logic        r_bready;
    logic [31:0] r_araddr;
    logic        r_arvalid;
    logic        r_rready;
    logic [31:0] r_rd_data;
    logic        r_done;

    // Next values for the master-side registers
    logic [31:0] w_awaddr_nxt;
    logic        w_awvalid_nxt;
    logic [31:0] w_wdata_nxt;
    logic        w_wvalid_nxt;
    logic        w_bready_nxt;
    logic [31:0] w_araddr_nxt;
    logic        w_arvalid_nxt;
    logic        w_rready_nxt;
    logic [31:0] w_rd_data_nxt;
    logic        w_done_nxt;

    // Slave-side ready registers and per-channel "already accepted" flags
    logic        r_awready;
    logic        r_wready;
    logic        r_arready;
    logic        r_aw_acc;
    logic        r_w_acc;
    logic        r_ar_acc;

    logic        w_awready_nxt;
    logic        w_wready_nxt;
    logic        w_arready_nxt;
    logic        w_aw_acc_nxt;
    logic        w_w_acc_nxt;
    logic        w_ar_acc_nxt;

    // Handshakes as seen at the coming rising edge
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_ar_hs;
    logic        w_b_hs;
    logic        w_r_hs;

    // In WRITE a low valid means that channel has already been accepted
    logic        w_aw_fin;
    logic        w_w_fin;

    assign w_aw_hs  = r_awvalid & r_awready;
    assign w_w_hs   = r_wvalid  & r_wready;
    assign w_ar_hs  = r_arvalid & r_arready;
    assign w_b_hs   = bvalid    & r_bready;
    assign w_r_hs   = rvalid    & r_rready;

    assign w_aw_fin = ~r_awvalid | w_aw_hs;
    assign w_w_fin  = ~r_wvalid  | w_w_hs;

    // State register; reset abandons whatever transaction is in flight
    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next master outputs; everything holds unless a transition changes it
    always_comb begin
        w_state_nxt   = r_state;
        w_awaddr_nxt  = r_awaddr;
        w_awvalid_nxt = r_awvalid;
        w_wdata_nxt   = r_wdata;
        w_wvalid_nxt  = r_wvalid;
        w_bready_nxt  = r_bready;
        w_araddr_nxt  = r_araddr;
        w_arvalid_nxt = r_arvalid;
        w_rready_nxt  = r_rready;
        w_rd_data_nxt = r_rd_data;
        w_done_nxt    = r_done;

        case (r_state)
            IDLE: begin
                // Launch address and data together on the first edge out of reset
                w_state_nxt   = WRITE;
                w_awvalid_nxt = 1'b1;
                w_awaddr_nxt  = WR_ADDR;
                w_wvalid_nxt  = 1'b1;
                w_wdata_nxt   = WR_DATA;
            end

            WRITE: begin
                // AW and W complete independently; each valid drops on its own handshake
                if (w_aw_hs) begin
                    w_awvalid_nxt = 1'b0;
                    w_awaddr_nxt  = 32'h0;
                end
                if (w_w_hs) begin
                    w_wvalid_nxt = 1'b0;
                    w_wdata_nxt  = 32'h0;
                end
                if (w_aw_fin && w_w_fin) begin
                    w_state_nxt  = WAIT_B;
                    w_bready_nxt = 1'b1;
                end
            end

            WAIT_B: begin
                if (w_b_hs) begin
                    w_state_nxt   = READ_ADDR;
                    w_bready_nxt  = 1'b0;
                    w_arvalid_nxt = 1'b1;
                    w_araddr_nxt  = RD_ADDR;
                end
            end

            READ_ADDR: begin
                if (w_ar_hs) begin
                    w_state_nxt   = WAIT_R;
                    w_arvalid_nxt = 1'b0;
                    w_araddr_nxt  = 32'h0;
                    w_rready_nxt  = 1'b1;
                end
            end

            WAIT_R: begin
                if (w_r_hs) begin
                    w_state_nxt   = DONE;
                    w_rd_data_nxt = rdata;
                    w_rready_nxt  = 1'b0;
                    w_done_nxt    = 1'b1;
                end
            end

            DONE: begin
                // Terminal: only reset leaves this state
                w_state_nxt = DONE;
            end

            default: begin
                // Unused encodings recover through IDLE with the bus quiet
                w_state_nxt   = IDLE;
                w_awvalid_nxt = 1'b0;
                w_awaddr_nxt  = 32'h0;
                w_wvalid_nxt  = 1'b0;
                w_wdata_nxt   = 32'h0;
                w_bready_nxt  = 1'b0;
                w_arvalid_nxt = 1'b0;
                w_araddr_nxt  = 32'h0;
                w_rready_nxt  = 1'b0;
            end
        endcase
    end

    // Master output registers; reset clears captured data and done as well
    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_awaddr  <= 32'h0;
            r_awvalid <= 1'b0;
            r_wdata   <= 32'h0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_araddr  <= 32'h0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_rd_data <= 32'h0;
            r_done    <= 1'b0;
        end else begin
            r_awaddr  <= w_awaddr_nxt;
            r_awvalid <= w_awvalid_nxt;
            r_wdata   <= w_wdata_nxt;
            r_wvalid  <= w_wvalid_nxt;
            r_bready  <= w_bready_nxt;
            r_araddr  <= w_araddr_nxt;
            r_arvalid <= w_arvalid_nxt;
            r_rready  <= w_rready_nxt;
            r_rd_data <= w_rd_data_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Slave readies: raise one edge after a pending valid is seen, drop on the handshake edge
    always_comb begin
        w_awready_nxt = r_awready;
        w_aw_acc_nxt  = r_aw_acc;
        if (w_aw_hs) begin
            w_awready_nxt = 1'b0;
            w_aw_acc_nxt  = 1'b1;
        end else if (r_awvalid && !r_awready && !r_aw_acc) begin
            w_awready_nxt = 1'b1;
        end

        w_wready_nxt = r_wready;
        w_w_acc_nxt  = r_w_acc;
        if (w_w_hs) begin
            w_wready_nxt = 1'b0;
            w_w_acc_nxt  = 1'b1;
        end else if (r_wvalid && !r_wready && !r_w_acc) begin
            w_wready_nxt = 1'b1;
        end

        w_arready_nxt = r_arready;
        w_ar_acc_nxt  = r_ar_acc;
        if (w_ar_hs) begin
            w_arready_nxt = 1'b0;
            w_ar_acc_nxt  = 1'b1;
        end else if (r_arvalid && !r_arready && !r_ar_acc) begin
            w_arready_nxt = 1'b1;
        end
    end

    // Slave ready registers; accepted flags only clear on reset since each channel is used once
    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_arready <= 1'b0;
            r_aw_acc  <= 1'b0;
            r_w_acc   <= 1'b0;
            r_ar_acc  <= 1'b0;
        end else begin
            r_awready <= w_awready_nxt;
            r_wready  <= w_wready_nxt;
            r_arready <= w_arready_nxt;
            r_aw_acc  <= w_aw_acc_nxt;
            r_w_acc   <= w_w_acc_nxt;
            r_ar_acc  <= w_ar_acc_nxt;
        end
    end

    assign awaddr    = r_awaddr;
    assign awvalid   = r_awvalid;
    assign awready   = r_awready;
    assign wdata     = r_wdata;
    assign wvalid    = r_wvalid;
    assign wready    = r_wready;
    assign bready    = r_bready;
    assign araddr    = r_araddr;
    assign arvalid   = r_arvalid;
    assign arready   = r_arready;
    assign rready    = r_rready;
    assign rd_data_q = r_rd_data;
    assign done      = r_done;

endmodule

// File: tb/tb_axi4_top.sv
// Bench for axi4_top: directed stimulus, a transaction-level model checked every cycle,
// and literal expectations at the key points of each sequence.
module tb_axi4_top;

    localparam logic [31:0] WR_ADDR = 32'h0000_0010;
    localparam logic [31:0] WR_DATA = 32'hDEAD_BEEF;
    localparam logic [31:0] RD_ADDR = 32'h0000_0010;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [31:0] rd_data_q;
    logic        done;

    always #5 clk = ~clk;

    axi4_top #(
        .WR_ADDR (WR_ADDR),
        .WR_DATA (WR_DATA),
        .RD_ADDR (RD_ADDR)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .awaddr    (awaddr),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wvalid    (wvalid),
        .wready    (wready),
        .bvalid    (bvalid),
        .bready    (bready),
        .araddr    (araddr),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .rready    (rready),
        .rd_data_q (rd_data_q),
        .done      (done)
    );

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Transaction-level model. phase: -1 idle, 0 write, 1 await B, 2 read address,
    // 3 await R, 4 finished. Each address/data channel is "pending" from the cycle its
    // valid rises; its age counts edges since then, ready is high at age 1 and the
    // channel is accepted on the following edge.
    int          m_phase = -1;
    bit          m_aw_p  = 1'b0;
    bit          m_w_p   = 1'b0;
    bit          m_ar_p  = 1'b0;
    int          m_aw_t  = 0;
    int          m_w_t   = 0;
    int          m_ar_t  = 0;
    logic [31:0] m_rd    = 32'h0;
    bit          m_done  = 1'b0;

    always @(posedge clk) begin
        if (reset_n) begin
            m_phase = -1;
            m_aw_p  = 1'b0;
            m_w_p   = 1'b0;
            m_ar_p  = 1'b0;
            m_rd    = 32'h0;
            m_done  = 1'b0;
        end else begin
            case (m_phase)
                -1: begin
                    m_phase = 0;
                    m_aw_p  = 1'b1;
                    m_aw_t  = 0;
                    m_w_p   = 1'b1;
                    m_w_t   = 0;
                end
                0: begin
                    if (m_aw_p) begin
                        if (m_aw_t == 1) m_aw_p = 1'b0;
                        else m_aw_t++;
                    end
                    if (m_w_p) begin
                        if (m_w_t == 1) m_w_p = 1'b0;
                        else m_w_t++;
                    end
                    if (!m_aw_p && !m_w_p) m_phase = 1;
                end
                1: begin
                    if (bvalid) begin
                        m_phase = 2;
                        m_ar_p  = 1'b1;
                        m_ar_t  = 0;
                    end
                end
                2: begin
                    if (m_ar_t == 1) begin
                        m_ar_p  = 1'b0;
                        m_phase = 3;
                    end else begin
                        m_ar_t++;
                    end
                end
                3: begin
                    if (rvalid) begin
                        m_rd    = rdata;
                        m_done  = 1'b1;
                        m_phase = 4;
                    end
                end
                default: ;
            endcase
        end
    end

    // Compare every output against the model on each falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_awvalid", awvalid, m_aw_p);
            check("m_awready", awready, m_aw_p && m_aw_t == 1);
            check("m_awaddr",  awaddr,  m_aw_p ? WR_ADDR : 32'h0);
            check("m_wvalid",  wvalid,  m_w_p);
            check("m_wready",  wready,  m_w_p && m_w_t == 1);
            check("m_wdata",   wdata,   m_w_p ? WR_DATA : 32'h0);
            check("m_bready",  bready,  m_phase == 1);
            check("m_arvalid", arvalid, m_ar_p);
            check("m_arready", arready, m_ar_p && m_ar_t == 1);
            check("m_araddr",  araddr,  m_ar_p ? RD_ADDR : 32'h0);
            check("m_rready",  rready,  m_phase == 3);
            check("m_rd_data", rd_data_q, m_rd);
            check("m_done",    done,    m_done);
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, " awaddr"},  awaddr,    32'h0);
        check({tag, " awvalid"}, awvalid,   32'h0);
        check({tag, " awready"}, awready,   32'h0);
        check({tag, " wdata"},   wdata,     32'h0);
        check({tag, " wvalid"},  wvalid,    32'h0);
        check({tag, " wready"},  wready,    32'h0);
        check({tag, " bready"},  bready,    32'h0);
        check({tag, " araddr"},  araddr,    32'h0);
        check({tag, " arvalid"}, arvalid,   32'h0);
        check({tag, " arready"}, arready,   32'h0);
        check({tag, " rready"},  rready,    32'h0);
        check({tag, " rd_data"}, rd_data_q, 32'h0);
        check({tag, " done"},    done,      32'h0);
    endtask

    // Wait (bounded) for bready (sel 0) or rready (sel 1); an expired bound fails the check
    task automatic wait_ready(input int sel, input string tag);
        int i;
        i = 0;
        while (((sel == 0) ? bready : rready) !== 1'b1 && i < 20) begin
            @(negedge clk);
            i++;
        end
        check({tag, (sel == 0) ? " bready wait" : " rready wait"},
              (sel == 0) ? bready : rready, 32'h1);
    endtask

    // Complete B then R from wherever the write currently is, returning data d
    task automatic finish_sequence(input string tag, input logic [31:0] d);
        wait_ready(0, tag);
        bvalid = 1'b1;
        @(negedge clk);
        bvalid = 1'b0;
        wait_ready(1, tag);
        rvalid = 1'b1;
        rdata  = d;
        @(negedge clk);
        rvalid = 1'b0;
        rdata  = 32'h0;
        check({tag, " rd_data"}, rd_data_q, d);
        check({tag, " done"},    done,      32'h1);
    endtask

    initial begin
        reset_n = 1'b1;
        bvalid  = 1'b0;
        rvalid  = 1'b0;
        rdata   = 32'h0;

        // Reset held for three edges
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check_all_zero("reset");
        reset_n = 1'b0;

        // First edge out of reset: address and data presented
        @(negedge clk);
        check("start awvalid", awvalid, 32'h1);
        check("start wvalid",  wvalid,  32'h1);
        check("start awaddr",  awaddr,  32'h0000_0010);
        check("start wdata",   wdata,   32'hDEAD_BEEF);
        check("start awready", awready, 32'h0);

        // Readies rise one edge later; pulse B and R early, which must be ignored
        @(negedge clk);
        check("aw ready pulse", awready, 32'h1);
        check("w ready pulse",  wready,  32'h1);
        bvalid = 1'b1;
        rvalid = 1'b1;
        rdata  = 32'hBAD0_BAD0;

        // Handshake edge: valids and readies drop, bready rises
        @(negedge clk);
        bvalid = 1'b0;
        rvalid = 1'b0;
        rdata  = 32'h0;
        check("hs awvalid", awvalid, 32'h0);
        check("hs awready", awready, 32'h0);
        check("hs wvalid",  wvalid,  32'h0);
        check("hs bready",  bready,  32'h1);

        // Still waiting for B despite the early pulse
        repeat (3) @(negedge clk);
        check("waitb bready",  bready,  32'h1);
        check("waitb arvalid", arvalid, 32'h0);
        check("waitb done",    done,    32'h0);

        bvalid = 1'b1;
        @(negedge clk);
        bvalid = 1'b0;
        check("b bready",  bready,  32'h0);
        check("b arvalid", arvalid, 32'h1);
        check("b araddr",  araddr,  32'h0000_0010);

        @(negedge clk);
        check("ar ready pulse", arready, 32'h1);
        @(negedge clk);
        check("ar arvalid", arvalid, 32'h0);
        check("ar arready", arready, 32'h0);
        check("ar rready",  rready,  32'h1);

        @(negedge clk);
        rvalid = 1'b1;
        rdata  = 32'h1234_5678;
        @(negedge clk);
        rvalid = 1'b0;
        rdata  = 32'hFFFF_FFFF;
        check("r rd_data", rd_data_q, 32'h1234_5678);
        check("r done",    done,      32'h1);
        check("r rready",  rready,    32'h0);

        // rvalid in the finished state must not disturb the captured data
        @(negedge clk);
        rvalid = 1'b1;
        rdata  = 32'hAAAA_5555;
        @(negedge clk);
        rvalid = 1'b0;
        @(negedge clk);
        check("held rd_data", rd_data_q, 32'h1234_5678);
        check("held done",    done,      32'h1);

        // Reset from the finished state, then run to WAIT_R and reset there
        reset_n = 1'b1;
        @(negedge clk);
        check_all_zero("reset2");
        reset_n = 1'b0;
        wait_ready(0, "seq2");
        bvalid = 1'b1;
        @(negedge clk);
        bvalid = 1'b0;
        wait_ready(1, "seq2");
        reset_n = 1'b1;
        @(negedge clk);
        check_all_zero("reset_waitr");
        reset_n = 1'b0;

        // Full sequence repeats after release
        @(negedge clk);
        check("rerun awvalid", awvalid, 32'h1);
        check("rerun wdata",   wdata,   32'hDEAD_BEEF);
        finish_sequence("rerun", 32'hCAFE_F00D);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

endmodule
